// File: rtl/window_acc_pkg.sv
// Shared stochastic-computing definitions: FSM encoding and fixed-point
// probability constants used by the bit-insertion and window-accumulate stages.
package window_acc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } sc_state_e;

  // Fixed-point probability format: 1.0 = 2^(FBITWIDTH-1), 0.5 = 2^(FBITWIDTH-2)
  localparam int SC_FBITWIDTH = 4;
  localparam int ONE          = 1 << (SC_FBITWIDTH - 1);
  localparam int HALF         = 1 << (SC_FBITWIDTH - 2);

  function automatic int sc_one(input int fbw);
    return 1 << (fbw - 1);
  endfunction

endpackage

// File: rtl/window_acc_cnt2prob.sv
// Combinational count-to-probability scaling with saturation to the
// largest representable fixed-point value.
module cnt2prob
  import window_acc_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int FBITWIDTH = 4
) (
  input  logic [BITWIDTH:0]    count,
  input  logic [BITWIDTH-1:0]  winlog2,
  output logic [FBITWIDTH-1:0] prob
);

  localparam int W = BITWIDTH + FBITWIDTH;
  localparam logic [W-1:0] PMAX = W'((sc_one(FBITWIDTH) << 1) - 1);

  logic [W-1:0] scaled;

  always_comb begin
    scaled = ({{(FBITWIDTH-1){1'b0}}, count} << (FBITWIDTH - 1)) >> winlog2;
    prob   = (scaled > PMAX) ? PMAX[FBITWIDTH-1:0] : scaled[FBITWIDTH-1:0];
  end

endmodule

// File: rtl/window_acc.sv
// Counts ones of a stochastic bitstream over back-to-back power-of-two windows
// and reports the count and fixed-point probability of each completed window.
module window_acc
  import window_acc_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int FBITWIDTH = 4
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iClr,
  input  logic                 iEn,
  input  logic [BITWIDTH-1:0]  iWindow,
  input  logic [BITWIDTH-1:0]  iWINLOG2,
  input  logic                 iBit,
  output logic [BITWIDTH:0]    oCount,
  output logic [FBITWIDTH-1:0] oProb,
  output logic                 oValid,
  output logic                 oErr
);

  sc_state_e state_q, state_d;

  logic [BITWIDTH-1:0]  cnt_q;
  logic [BITWIDTH:0]    acc_q;
  logic [BITWIDTH:0]    sum;
  logic [BITWIDTH-1:0]  win_m1;
  logic [FBITWIDTH-1:0] prob_d;
  logic                 acc_step;
  logic                 close;
  logic                 win_zero;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (iClr) state_d = win_zero ? ST_IDLE : ST_ACC;
  end

  // iClr has priority: a bit presented together with iClr is dropped.
  always_comb begin
    win_zero = (iWindow == '0);
    win_m1   = iWindow - BITWIDTH'(1);
    acc_step = (state_q == ST_ACC) && iEn && !iClr;
    close    = acc_step && (cnt_q == '0);
    sum      = acc_q + {{BITWIDTH{1'b0}}, iBit};
  end

  cnt2prob #(
    .BITWIDTH  (BITWIDTH),
    .FBITWIDTH (FBITWIDTH)
  ) u_cnt2prob (
    .count   (sum),
    .winlog2 (iWINLOG2),
    .prob    (prob_d)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      oCount <= '0;
      oProb  <= '0;
      oValid <= 1'b0;
      oErr   <= 1'b0;
    end else begin
      oValid <= close;
      if (iClr) begin
        acc_q <= '0;
        cnt_q <= win_zero ? '0 : win_m1;
        oErr  <= win_zero;
      end else if (close) begin
        oCount <= sum;
        oProb  <= prob_d;
        acc_q  <= '0;
        cnt_q  <= win_m1;
      end else if (acc_step) begin
        acc_q <= sum;
        cnt_q <= cnt_q - BITWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_window_acc.sv
// Directed scenarios plus random traffic against a window-counting reference model.
module tb_window_acc;

  localparam int BW  = 8;
  localparam int FBW = 4;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iClr = 1'b0;
  logic          iEn = 1'b0;
  logic          iBit = 1'b0;
  logic [BW-1:0] iWindow = '0;
  logic [BW-1:0] iWINLOG2 = '0;
  logic [BW:0]   oCount;
  logic [FBW-1:0] oProb;
  logic          oValid;
  logic          oErr;

  window_acc #(.BITWIDTH(BW), .FBITWIDTH(FBW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iEn(iEn),
    .iWindow(iWindow), .iWINLOG2(iWINLOG2), .iBit(iBit),
    .oCount(oCount), .oProb(oProb), .oValid(oValid), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad = 0;

  // Reference model: bits seen / ones seen in the current window
  bit    m_act, m_vld, m_err;
  int    m_seen, m_ones, m_cnt, m_prob;
  int    win, lg;
  int    pulses;
  string scen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", scen, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_vld = 0; m_err = 0;
    m_seen = 0; m_ones = 0; m_cnt = 0; m_prob = 0;
  endtask

  function automatic int ref_prob(input int ones, input int l2);
    int p;
    p = (ones * (2 ** (FBW - 1))) / (2 ** l2);
    return (p > (2 ** FBW) - 1) ? (2 ** FBW) - 1 : p;
  endfunction

  task automatic check_all();
    chk("valid", 32'(oValid), 32'(m_vld));
    chk("count", 32'(oCount), 32'(m_cnt));
    chk("prob",  32'(oProb),  32'(m_prob));
    chk("err",   32'(oErr),   32'(m_err));
  endtask

  task automatic step(input bit clr, input bit en, input bit b);
    iClr = clr; iEn = en; iBit = b;
    iWindow = BW'(win); iWINLOG2 = BW'(lg);
    @(posedge iClk);
    m_vld = 0;
    if (clr) begin
      if (win != 0) begin m_act = 1; m_seen = 0; m_ones = 0; m_err = 0; end
      else begin m_act = 0; m_err = 1; end
    end else if (m_act && en) begin
      m_seen++;
      m_ones += int'(b);
      if (m_seen == win) begin
        m_cnt = m_ones; m_prob = ref_prob(m_ones, lg); m_vld = 1;
        m_seen = 0; m_ones = 0;
      end
    end
    #1;
    check_all();
    if (oValid === 1'b1) pulses++;
    iClr = 0; iEn = 0; iBit = 0;
  endtask

  initial begin
    int last_pulse;
    int gap_bad;
    model_reset();
    scen = "reset";
    #12;
    check_all();
    iRstN = 1'b1;

    // V1
    scen = "V1"; win = 16; lg = 4; pulses = 0;
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, bit'(i % 2));
    chk("vld_now", 32'(oValid), 32'd1);
    chk("cnt8", 32'(oCount), 32'd8);
    chk("prob4", 32'(oProb), 32'd4);

    // V2: three back-to-back all-ones windows
    scen = "V2"; win = 8; lg = 3; pulses = 0; last_pulse = -1; gap_bad = 0;
    step(1, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 1);
      if (oValid === 1'b1) begin
        if (last_pulse >= 0 && i - last_pulse != 8) gap_bad++;
        last_pulse = i;
      end
    end
    chk("pulses", 32'(pulses), 32'd3);
    chk("spacing", 32'(gap_bad), 32'd0);
    chk("prob8", 32'(oProb), 32'd8);

    // V3: pause mid-window
    scen = "V3"; win = 16; lg = 4; pulses = 0;
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    for (int i = 0; i < 11; i++) step(0, 1, bit'(i < 3));
    chk("pulses", 32'(pulses), 32'd1);
    chk("cnt8", 32'(oCount), 32'd8);

    // V4: reset mid-window
    scen = "V4"; win = 16; lg = 4;
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom));
    #2 iRstN = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge iClk); #1;
    check_all();
    #2 iRstN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) step(0, 1, 1);
    chk("no_pulse_before_clr", 32'(pulses), 32'd0);
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("pulses", 32'(pulses), 32'd1);
    chk("cnt0", 32'(oCount), 32'd0);

    // V5: illegal window, then recovery
    scen = "V5"; win = 0; lg = 0; pulses = 0;
    step(1, 0, 0);
    chk("err1", 32'(oErr), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 1, 1);
    chk("no_pulse_idle", 32'(pulses), 32'd0);
    win = 4; lg = 2;
    step(1, 0, 0);
    chk("err0", 32'(oErr), 32'd0);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    chk("cnt3", 32'(oCount), 32'd3);
    chk("prob6", 32'(oProb), 32'd6);

    // V6: clear collides with the closing bit
    scen = "V6"; win = 4; lg = 2; pulses = 0;
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(1, 1, 1);
    chk("no_pulse", 32'(pulses), 32'd0);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 0); step(0, 1, 0);
    chk("pulses", 32'(pulses), 32'd1);
    chk("cnt1", 32'(oCount), 32'd1);

    // Boundaries: largest window all ones, window of one, saturation
    scen = "big"; win = 128; lg = 7;
    step(1, 0, 0);
    for (int i = 0; i < 128; i++) step(0, 1, 1);
    chk("cnt128", 32'(oCount), 32'd128);
    scen = "win1"; win = 1; lg = 0;
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, bit'(i % 3 == 0));
    scen = "sat"; win = 8; lg = 1;
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    chk("prob15", 32'(oProb), 32'd15);

    // Random traffic with occasional restarts
    scen = "rand"; lg = 2; win = 4;
    step(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        lg = $urandom_range(0, 5); win = 1 << lg;
        step(1, 1'($urandom), 1'($urandom));
      end else begin
        step(0, $urandom_range(0, 3) != 0, 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
